mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler.sv | 115 +++++++++++
 tb/tb_mult_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// Issue/retire scheduler for one shared pipelined multiplier.
// Keeps a {valid, tag} shadow of the mult pipe and arbitrates requesters.
module mult_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int MULT_STAGES = 4,
  parameter int TAG_W       = 6,
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(MULT_STAGES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  input  logic                     flush_i,
  input  logic                     cdb_grant_i,
  input  logic                     mult_done_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     mult_start_o,
  output logic [SEL_W-1:0]         mult_sel_o,
  output logic                     mult_stall_o,
  output logic                     cdb_req_o,
  output logic [TAG_W-1:0]         cdb_tag_o,
  output logic [CNT_W-1:0]         inflight_o,
  output logic                     sync_err_o
);

  logic [MULT_STAGES-1:0]            vld_q, vld_d;
  logic [MULT_STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [SEL_W-1:0]                  rr_q, rr_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              err_q, err_d;

  logic             stall;
  logic             blk;
  logic             hit;
  logic [SEL_W-1:0] sel;
  logic [TAG_W-1:0] gtag;
  int               k;

  assign stall = vld_q[MULT_STAGES-1] & ~cdb_grant_i;
  // Reset is folded in so no grant escapes while the block is held.
  assign blk   = stall | flush_i | ~rst_ni;

  // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    k   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!blk && !hit && req_valid_i[k]) begin
        hit = 1'b1;
        sel = SEL_W'(k);
      end
    end
  end

  assign gtag = req_tag_i[sel*TAG_W +: TAG_W];

  // Shadow pipe advance, pointer update, occupancy and sticky error.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    rr_d  = rr_q;
    err_d = err_q | ((mult_done_i != vld_q[MULT_STAGES-1]) & ~flush_i);
    cnt_d = '0;
    if (flush_i) begin
      vld_d = '0;
      rr_d  = '0;
    end else begin
      if (!stall) begin
        for (int i = MULT_STAGES - 1; i > 0; i--) begin
          vld_d[i] = vld_q[i-1];
          tag_d[i] = tag_q[i-1];
        end
        vld_d[0] = hit;
        tag_d[0] = hit ? gtag : '0;
      end
      if (hit) begin
        rr_d = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
      end
    end
    for (int i = 0; i < MULT_STAGES; i++) begin
      cnt_d = cnt_d + CNT_W'(vld_d[i]);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      tag_q <= '0;
      rr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign grant_o      = hit ? (NUM_REQ'(1) << sel) : '0;
  assign mult_start_o = hit;
  assign mult_sel_o   = sel;
  assign mult_stall_o = stall;
  assign cdb_req_o    = vld_q[MULT_STAGES-1];
  assign cdb_tag_o    = tag_q[MULT_STAGES-1];
  assign inflight_o   = cnt_q;
  assign sync_err_o   = err_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: directed table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_mult_scheduler;

  localparam int S = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rv;
  logic [11:0] tags;
  logic        fl, cg, md;
  logic [1:0]  grant;
  logic        start;
  logic [0:0]  sel;
  logic        stall, creq;
  logic [5:0]  ctag;
  logic [2:0]  infl;
  logic        serr;

  int total = 0;
  int bad   = 0;

  mult_scheduler dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (rv),
    .req_tag_i   (tags),
    .flush_i     (fl),
    .cdb_grant_i (cg),
    .mult_done_i (md),
    .grant_o     (grant),
    .mult_start_o(start),
    .mult_sel_o  (sel),
    .mult_stall_o(stall),
    .cdb_req_o   (creq),
    .cdb_tag_o   (ctag),
    .inflight_o  (infl),
    .sync_err_o  (serr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rv;
    logic       cg;
    logic [1:0] eg;
    logic       ereq;
    logic [5:0] etag;
    int         einf;
    logic       estall;
  } vec_t;

  typedef struct {
    logic [5:0] tag;
    int         left;
  } op_t;

  vec_t tbl[$];
  op_t  q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string p, input logic [1:0] eg,
                           input logic ereq, input logic [5:0] etag,
                           input int einf, input logic estall,
                           input logic eerr);
    chk({p, ".grant"}, int'(grant), int'(eg));
    chk({p, ".start"}, int'(start), int'(|eg));
    chk({p, ".sel"}, int'(sel), int'(eg[1]));
    chk({p, ".stall"}, int'(stall), int'(estall));
    chk({p, ".cdb_req"}, int'(creq), int'(ereq));
    if (ereq) chk({p, ".cdb_tag"}, int'(ctag), int'(etag));
    chk({p, ".inflight"}, int'(infl), einf);
    chk({p, ".sync_err"}, int'(serr), int'(eerr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic g,
                       input logic f, input logic d);
    rv = r;
    cg = g;
    fl = f;
    md = d;
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int         rr;
    int         gk;
    int         kk;
    logic       ereq, estall, serr_m;
    logic [1:0] eg;
    logic [5:0] etag;
    op_t        op;

    rst_n = 1'b0;
    tags  = {6'h2A, 6'h15};
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    #3;
    check_all("reset", 2'b00, 1'b0, 6'h00, 0, 1'b0, 1'b0);
    chk("reset.cdb_tag", int'(ctag), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cycle, round-robin, stall and hold behaviour from a clean reset
    tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b0, 6'h00, 0, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 2'b10, 1'b0, 6'h00, 1, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b0, 6'h00, 2, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 2'b10, 1'b0, 6'h00, 3, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 6'h15, 4, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 6'h2A, 3, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 6'h15, 2, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 6'h2A, 1, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 6'h00, 0, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 2'b01, 1'b0, 6'h00, 0, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 6'h00, 1, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 6'h00, 1, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 6'h00, 1, 1'b0});
    tbl.push_back('{2'b01, 1'b0, 2'b00, 1'b1, 6'h15, 1, 1'b1});
    tbl.push_back('{2'b01, 1'b0, 2'b00, 1'b1, 6'h15, 1, 1'b1});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 6'h15, 1, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 6'h00, 0, 1'b0});
    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].cg, 1'b0, tbl[i].ereq);
      #3;
      check_all($sformatf("tbl%0d", i), tbl[i].eg, tbl[i].ereq,
                tbl[i].etag, tbl[i].einf, tbl[i].estall, 1'b0);
      step();
    end

    // flush squashes three ops and restarts arbitration at 0
    do_reset();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0, 1, 2: drive(2'b11, 1'b1, 1'b0, 1'b0);
        3:       drive(2'b11, 1'b1, 1'b1, 1'b0);
        4:       drive(2'b11, 1'b1, 1'b0, 1'b0);
        8:       drive(2'b00, 1'b1, 1'b0, 1'b1);
        default: drive(2'b00, 1'b1, 1'b0, 1'b0);
      endcase
      #3;
      case (c)
        0: check_all("fl0", 2'b01, 0, 0, 0, 0, 0);
        1: check_all("fl1", 2'b10, 0, 0, 1, 0, 0);
        2: check_all("fl2", 2'b01, 0, 0, 2, 0, 0);
        3: check_all("fl3", 2'b00, 0, 0, 3, 0, 0);
        4: check_all("fl4", 2'b01, 0, 0, 0, 0, 0);
        8: check_all("fl8", 2'b00, 1, 6'h15, 1, 0, 0);
        9: check_all("fl9", 2'b00, 0, 0, 0, 0, 0);
        default: check_all($sformatf("fl%0d", c), 2'b00, 0, 0, 1, 0, 0);
      endcase
      step();
    end

    // back-to-back issue keeps the pipe full
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(2'b01, 1'b1, 1'b0, c >= S);
      #3;
      check_all($sformatf("full%0d", c), 2'b01, c >= S, 6'h15,
                (c < S) ? c : S, 1'b0, 1'b0);
      step();
    end

    // sticky error, then async reset mid-cycle with three in flight
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 1'b1);
    #3;
    check_all("ar0", 2'b01, 0, 0, 0, 0, 0);
    step();
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    #3;
    check_all("ar1", 2'b01, 0, 0, 1, 0, 1);
    step();
    #3;
    check_all("ar2", 2'b01, 0, 0, 2, 0, 1);
    step();
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    #3;
    check_all("ar3", 2'b00, 0, 0, 3, 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.async.inflight", int'(infl), 0);
    chk("ar.async.cdb_req", int'(creq), 0);
    chk("ar.async.sync_err", int'(serr), 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #3;
      check_all($sformatf("arpost%0d", c), 2'b00, 0, 0, 0, 0, 0);
      step();
    end

    // random traffic against a queue-of-ops model
    do_reset();
    rr     = 0;
    serr_m = 1'b0;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      rv   = 2'($urandom);
      tags = 12'($urandom);
      fl   = ($urandom_range(0, 15) == 0);
      cg   = ($urandom_range(0, 3) != 0);
      ereq = (q.size() > 0) && (q[0].left == 0);
      md   = ereq;
      estall = ereq && !cg;
      gk = -1;
      if (!estall && !fl) begin
        for (int i = 0; i < 2; i++) begin
          kk = (rr + i) % 2;
          if (gk < 0 && rv[kk]) gk = kk;
        end
      end
      eg = 2'b00;
      if (gk >= 0) eg[gk] = 1'b1;
      etag = ereq ? q[0].tag : 6'h00;
      #3;
      check_all("rnd", eg, ereq, etag, q.size(), estall, serr_m);
      if (md != ereq && !fl) serr_m = 1'b1;
      if (fl) begin
        q.delete();
        rr = 0;
      end else begin
        if (!estall) begin
          if (ereq) void'(q.pop_front());
          foreach (q[i]) q[i].left--;
          if (gk >= 0) begin
            op.tag  = tags[gk*6 +: 6];
            op.left = S - 1;
            q.push_back(op);
          end
        end
        if (gk >= 0) rr = (gk + 1) % 2;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
